// File: rtl/io_interval_timer_pkg.sv
// Shared types, register offsets and CTRL bit positions for the io interval timer.
package io_interval_timer_pkg;

    typedef logic [31:0] scalar_t;

    localparam scalar_t TIMER_CTRL   = 32'h0000_0000;
    localparam scalar_t TIMER_LOAD   = 32'h0000_0004;
    localparam scalar_t TIMER_COUNT  = 32'h0000_0008;
    localparam scalar_t TIMER_STATUS = 32'h0000_000c;

    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_PERIODIC_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 2;
    localparam int unsigned STATUS_PENDING_BIT = 0;

    // Field order puts enable at bit0 so the struct maps directly onto the CTRL word.
    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic enable;
    } ctrl_t;

    function automatic scalar_t ctrl_to_word(input ctrl_t c);
        return 32'(c);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 0..PRESCALE-1 divider; tick is high in the cycle the divider sits at its last value.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Clear has priority so a restart always begins a fresh PRESCALE-cycle interval.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_interval_timer.sv
// Memory-mapped interval timer: one-shot/periodic countdown with pending flag and maskable level interrupt.
module io_interval_timer
    import io_interval_timer_pkg::*;
#(
    parameter scalar_t     BASE_ADDRESS = 32'h0000_0060,
    parameter int unsigned PRESCALE     = 50,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    io_write_en,
    input  logic    io_read_en,
    input  scalar_t io_address,
    input  scalar_t io_write_data,
    output scalar_t io_read_data,
    output logic    interrupt_req
);

    localparam scalar_t ADDR_CTRL   = BASE_ADDRESS + TIMER_CTRL;
    localparam scalar_t ADDR_LOAD   = BASE_ADDRESS + TIMER_LOAD;
    localparam scalar_t ADDR_COUNT  = BASE_ADDRESS + TIMER_COUNT;
    localparam scalar_t ADDR_STATUS = BASE_ADDRESS + TIMER_STATUS;

    ctrl_t                  ctrl_q;
    ctrl_t                  ctrl_d;
    logic [COUNT_WIDTH-1:0] load_q;
    logic [COUNT_WIDTH-1:0] load_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   pending_q;
    logic                   pending_d;
    scalar_t                rdata_q;
    scalar_t                rdata_d;
    logic                   irq_q;
    logic                   irq_d;

    logic wr_ctrl;
    logic wr_load;
    logic wr_status;
    logic start;
    logic tick;
    logic expire;

    assign wr_ctrl   = io_write_en && (io_address == ADDR_CTRL);
    assign wr_load   = io_write_en && (io_address == ADDR_LOAD);
    assign wr_status = io_write_en && (io_address == ADDR_STATUS);
    assign start     = wr_ctrl && io_write_data[CTRL_ENABLE_BIT];

    // Any CTRL write freezes the divider for that cycle, so a stop holds it and a tick is never lost silently.
    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (ctrl_q.enable && !wr_ctrl),
        .clear   (start),
        .tick    (tick)
    );

    assign expire = tick && !wr_ctrl && (count_q == '0);

    // Register updates; a CTRL write overrides a coincident tick.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;

        if (wr_load) begin
            load_d = io_write_data[COUNT_WIDTH-1:0];
        end

        if (wr_ctrl) begin
            ctrl_d.enable   = io_write_data[CTRL_ENABLE_BIT];
            ctrl_d.periodic = io_write_data[CTRL_PERIODIC_BIT];
            ctrl_d.irq_en   = io_write_data[CTRL_IRQ_EN_BIT];
            if (start) begin
                count_d = load_q;
            end
        end else if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - COUNT_WIDTH'(1);
            end else if (ctrl_q.periodic) begin
                count_d = load_q;
            end else begin
                ctrl_d.enable = 1'b0;
            end
        end
    end

    // Expiry beats a simultaneous write-1-to-clear.
    always_comb begin
        pending_d = pending_q;
        if (expire) begin
            pending_d = 1'b1;
        end else if (wr_status && io_write_data[STATUS_PENDING_BIT]) begin
            pending_d = 1'b0;
        end
    end

    // Non-matching or idle cycles return zero so the top-level mux can OR slaves together.
    always_comb begin
        rdata_d = '0;
        if (io_read_en) begin
            case (io_address)
                ADDR_CTRL:   rdata_d = ctrl_to_word(ctrl_q);
                ADDR_LOAD:   rdata_d = 32'(load_q);
                ADDR_COUNT:  rdata_d = 32'(count_q);
                ADDR_STATUS: rdata_d = 32'(pending_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    assign irq_d = pending_q && ctrl_q.irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign io_read_data  = rdata_q;
    assign interrupt_req = irq_q;

endmodule

// File: tb/tb_io_interval_timer.sv
// Directed bench for io_interval_timer: a PRESCALE=4 instance at 'h60 and a PRESCALE=1 instance at 'h100.
module tb_io_interval_timer;
    import io_interval_timer_pkg::*;

    localparam scalar_t B4 = 32'h0000_0060;
    localparam scalar_t B1 = 32'h0000_0100;

    logic    clk = 1'b0;
    logic    reset_n = 1'b0;
    logic    io_write_en = 1'b0;
    logic    io_read_en = 1'b0;
    scalar_t io_address = '0;
    scalar_t io_write_data = '0;
    scalar_t rd4;
    scalar_t rd1;
    logic    irq4;
    logic    irq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_interval_timer #(.BASE_ADDRESS(B4), .PRESCALE(4), .COUNT_WIDTH(32)) dut4 (
        .clk(clk), .reset_n(reset_n), .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(rd4), .interrupt_req(irq4)
    );

    io_interval_timer #(.BASE_ADDRESS(B1), .PRESCALE(1), .COUNT_WIDTH(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(rd1), .interrupt_req(irq1)
    );

    task automatic check(input string tag, input scalar_t obs, input scalar_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge; returns at the following negedge.
    task automatic wr(input scalar_t addr, input scalar_t data);
        io_address    = addr;
        io_write_data = data;
        io_write_en   = 1'b1;
        @(negedge clk);
        io_write_en   = 1'b0;
    endtask

    task automatic rdchk4(input string tag, input scalar_t addr, input scalar_t exp);
        io_address = addr;
        io_read_en = 1'b1;
        @(negedge clk);
        io_read_en = 1'b0;
        check(tag, rd4, exp);
    endtask

    task automatic rdchk1(input string tag, input scalar_t addr, input scalar_t exp);
        io_address = addr;
        io_read_en = 1'b1;
        @(negedge clk);
        io_read_en = 1'b0;
        check(tag, rd1, exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #1;
        checkb("rst_irq4", irq4, 1'b0);
        check("rst_rdata4", rd4, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rdchk4("rst_ctrl", B4 + 32'h0, 32'h0);
        rdchk4("rst_load", B4 + 32'h4, 32'h0);
        rdchk4("rst_count", B4 + 32'h8, 32'h0);
        rdchk4("rst_status", B4 + 32'hc, 32'h0);
        rdchk1("rst_status1", B1 + 32'hc, 32'h0);

        // Periodic, PRESCALE=4, LOAD=2: expiry every 12 cycles after the CTRL write edge E
        wr(B4 + 32'h4, 32'd2);
        wr(B4 + 32'h0, 32'h7);
        ticks(4);
        rdchk4("per_count_e4", B4 + 32'h8, 32'd1);
        ticks(3);
        rdchk4("per_count_e8", B4 + 32'h8, 32'd0);
        ticks(3);
        checkb("per_irq_e12", irq4, 1'b0);
        rdchk4("per_pending_e12", B4 + 32'hc, 32'h1);
        checkb("per_irq_e13", irq4, 1'b1);
        wr(B4 + 32'hc, 32'h1);
        ticks(1);
        checkb("per_irq_cleared", irq4, 1'b0);
        ticks(9);
        checkb("per_irq_e24_pre", irq4, 1'b0);
        ticks(1);
        checkb("per_irq_e25", irq4, 1'b1);
        wr(B4 + 32'hc, 32'h1);
        ticks(10);
        checkb("per_irq_e36_pre", irq4, 1'b0);
        ticks(1);
        checkb("per_irq_e37", irq4, 1'b1);

        // Clear in the expiry cycle (E+48) loses; clear one cycle later wins
        wr(B4 + 32'hc, 32'h1);
        ticks(9);
        wr(B4 + 32'hc, 32'h1);
        wr(B4 + 32'hc, 32'h1);
        checkb("clr_same_cycle_set_wins", irq4, 1'b1);
        ticks(1);
        checkb("clr_next_cycle_irq", irq4, 1'b0);
        rdchk4("clr_next_cycle_status", B4 + 32'hc, 32'h0);

        // Masking: irq_en=0 keeps interrupt low while pending reads 1
        wr(B4 + 32'h0, 32'h3);
        ticks(12);
        checkb("mask_irq_a", irq4, 1'b0);
        rdchk4("mask_status", B4 + 32'hc, 32'h1);
        checkb("mask_irq_b", irq4, 1'b0);
        rdchk4("mask_ctrl", B4 + 32'h0, 32'h3);
        wr(B4 + 32'h4, 32'd7);
        rdchk4("load_no_direct_effect", B4 + 32'h8, 32'd2);
        ticks(1);
        // Restart mid-prescale: divider would otherwise tick two cycles later
        wr(B4 + 32'h0, 32'h3);
        ticks(3);
        rdchk4("restart_count_7", B4 + 32'h8, 32'd7);
        rdchk4("restart_count_6", B4 + 32'h8, 32'd6);
        wr(B4 + 32'h0, 32'h0);
        ticks(10);
        rdchk4("stop_count_holds", B4 + 32'h8, 32'd6);
        rdchk4("stop_pending_holds", B4 + 32'hc, 32'h1);
        wr(B4 + 32'h0, 32'h4);
        checkb("unmask_irq_lag", irq4, 1'b0);
        ticks(1);
        checkb("unmask_irq", irq4, 1'b1);
        wr(B4 + 32'hc, 32'h1);
        ticks(1);
        checkb("unmask_cleared", irq4, 1'b0);

        // Decode
        rdchk4("decode_74", 32'h0000_0074, 32'h0);
        rdchk4("decode_5c", 32'h0000_005c, 32'h0);
        wr(B4 + 32'h8, 32'h1234);
        rdchk4("count_ro", B4 + 32'h8, 32'd6);
        wr(B4 + 32'h4, 32'hffff_ffff);
        rdchk4("load_all_ones", B4 + 32'h4, 32'hffff_ffff);
        wr(B4 + 32'h0, 32'hffff_fff8);
        rdchk4("ctrl_upper_zero", B4 + 32'h0, 32'h0);
        wr(32'h0000_0070, 32'h7);
        rdchk4("unmapped_write_ignored", B4 + 32'h0, 32'h0);

        // One-shot, PRESCALE=1, LOAD=5: pending at E+6, interrupt at E+7
        wr(B1 + 32'h4, 32'd5);
        wr(B1 + 32'h0, 32'h5);
        ticks(5);
        checkb("os_irq_e5", irq1, 1'b0);
        rdchk1("os_status_e5", B1 + 32'hc, 32'h0);
        checkb("os_irq_e6", irq1, 1'b0);
        ticks(1);
        checkb("os_irq_e7", irq1, 1'b1);
        rdchk1("os_ctrl_after", B1 + 32'h0, 32'h4);
        rdchk1("os_count_after", B1 + 32'h8, 32'h0);
        wr(B1 + 32'hc, 32'h1);
        ticks(100);
        checkb("os_no_rerun_irq", irq1, 1'b0);
        rdchk1("os_no_rerun_status", B1 + 32'hc, 32'h0);
        rdchk1("os_count_stays", B1 + 32'h8, 32'h0);

        // Reset while counting with interrupt asserted and a read held on the bus
        wr(B4 + 32'h4, 32'd3);
        wr(B4 + 32'h0, 32'h7);
        ticks(17);
        checkb("prerst_irq", irq4, 1'b1);
        io_address = B4;
        io_read_en = 1'b1;
        @(negedge clk);
        check("prerst_rdata", rd4, 32'h7);
        #2;
        reset_n = 1'b0;
        #1;
        checkb("async_rst_irq", irq4, 1'b0);
        check("async_rst_rdata", rd4, 32'h0);
        io_read_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rdchk4("postrst_count", B4 + 32'h8, 32'h0);
        rdchk4("postrst_ctrl", B4 + 32'h0, 32'h0);
        ticks(30);
        rdchk4("postrst_idle_status", B4 + 32'hc, 32'h0);
        checkb("postrst_irq", irq4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
